// File: rtl/crc32x64_frame_ctrl.sv
// Frame sequencer for the 64-bit CRC32 pipeline engine: drives the engine from a
// sop/eop word stream and appends one {TRAILER_HI, crc} trailer word per frame.
module crc32x64_frame_ctrl #(
  parameter int unsigned LATENCY    = 7,
  parameter logic [31:0] TRAILER_HI = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [63:0] in_data,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic [63:0] out_data,
  output logic        crc_ce,
  output logic        crc_valid_in,
  output logic        crc_init_in,
  output logic [63:0] crc_data_in,
  input  logic [63:0] crc_data_out,
  input  logic [31:0] crc_crc,
  output logic [31:0] frame_count,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic vld;
    logic sop;
    logic eop;
  } dl_entry_t;

  state_t      r_state;
  state_t      w_state_nxt;
  dl_entry_t   r_dl [LATENCY];
  dl_entry_t   w_tail;
  logic        w_ce;
  logic        w_accept;
  logic        w_drop;
  logic        w_init;
  logic        w_err;
  logic        r_out_valid;
  logic        r_out_sop;
  logic        r_out_eop;
  logic [63:0] r_out_data;
  logic [31:0] r_crc_hold;
  logic        r_trailer_pend;
  logic [31:0] r_frame_count;
  logic [15:0] r_err_count;

  // The whole pipeline (engine, delay line, output register) stalls together.
  assign w_ce     = out_ready | ~r_out_valid;
  assign in_ready = rst_n & w_ce & (r_state != GAP);
  assign w_accept = in_valid & in_ready;
  assign w_drop   = w_accept & (r_state == IDLE) & ~in_sop;
  assign w_init   = w_accept & (r_state == IDLE) & in_sop;
  assign w_err    = w_drop | (w_accept & (r_state == FRAME) & in_sop);

  assign crc_ce       = w_ce | ~rst_n;
  assign crc_valid_in = w_accept & ~w_drop;
  assign crc_init_in  = w_init;
  assign crc_data_in  = in_data;

  assign w_tail = r_dl[LATENCY-1];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_init) w_state_nxt = in_eop ? GAP : FRAME;
      FRAME:   if (w_accept && in_eop) w_state_nxt = GAP;
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // sample pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (w_ce) begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the delay line is reset even though it is array-like storage: its tail
  // alone qualifies out_valid, so stale entries after reset must read as empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LATENCY); i++) r_dl[i] <= '0;
    end else if (w_ce) begin
      r_dl[0] <= '{vld: crc_valid_in, sop: w_init, eop: crc_valid_in & in_eop};
      for (int i = 1; i < int'(LATENCY); i++) r_dl[i] <= r_dl[i-1];
    end
  end

  // The GAP state guarantees an empty tail slot right after each eop word,
  // which is where the trailer goes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_sop      <= 1'b0;
      r_out_eop      <= 1'b0;
      r_out_data     <= '0;
      r_crc_hold     <= '0;
      r_trailer_pend <= 1'b0;
      r_frame_count  <= '0;
    end else if (w_ce) begin
      if (w_tail.vld) begin
        r_out_valid <= 1'b1;
        r_out_sop   <= w_tail.sop;
        r_out_eop   <= 1'b0;
        r_out_data  <= crc_data_out;
        if (w_tail.eop) begin
          r_crc_hold     <= crc_crc;
          r_trailer_pend <= 1'b1;
        end
      end else if (r_trailer_pend) begin
        r_out_valid    <= 1'b1;
        r_out_sop      <= 1'b0;
        r_out_eop      <= 1'b1;
        r_out_data     <= {TRAILER_HI, r_crc_hold};
        r_trailer_pend <= 1'b0;
        r_frame_count  <= r_frame_count + 32'd1;
      end else begin
        r_out_valid <= 1'b0;
        r_out_sop   <= 1'b0;
        r_out_eop   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_err && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_sop     = r_out_sop;
  assign out_eop     = r_out_eop;
  assign out_data    = r_out_data;
  assign frame_count = r_frame_count;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_crc32x64_frame_ctrl.sv
// Bench for crc32x64_frame_ctrl: behavioural CRC32 engine model plus a queue
// scoreboard of expected output words (data, sop, trailer/eop).
module tb_crc32x64_frame_ctrl;

  localparam int unsigned LAT  = 7;
  localparam logic [31:0] POLY = 32'hEDB8_8320;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_ready;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic [63:0] out_data;
  logic        crc_ce;
  logic        crc_valid_in;
  logic        crc_init_in;
  logic [63:0] crc_data_in;
  logic [63:0] crc_data_out;
  logic [31:0] crc_crc;
  logic [31:0] frame_count;
  logic [15:0] err_count;

  crc32x64_frame_ctrl #(.LATENCY(LAT), .TRAILER_HI(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_sop       (in_sop),
    .in_eop       (in_eop),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_data     (out_data),
    .crc_ce       (crc_ce),
    .crc_valid_in (crc_valid_in),
    .crc_init_in  (crc_init_in),
    .crc_data_in  (crc_data_in),
    .crc_data_out (crc_data_out),
    .crc_crc      (crc_crc),
    .frame_count  (frame_count),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model: reflected CRC32, init 0xFFFFFFFF, final inversion, bytes
  // taken little-endian (bit 0 first); LAT-stage pipeline, no reset.
  function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [63:0] w);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 64; i++) begin
      fb = r[0] ^ w[i];
      r  = r >> 1;
      if (fb) r = r ^ POLY;
    end
    return r;
  endfunction

  logic [63:0] eng_d [LAT];
  logic [31:0] eng_c [LAT];
  logic [31:0] eng_acc;
  logic [31:0] eng_nxt;

  assign eng_nxt = crc_bits(crc_init_in ? 32'hFFFF_FFFF : eng_acc, crc_data_in);

  always @(posedge clk) begin
    if (crc_ce) begin
      if (crc_valid_in) eng_acc <= eng_nxt;
      eng_d[0] <= crc_data_in;
      eng_c[0] <= ~eng_nxt;
      for (int i = 1; i < int'(LAT); i++) begin
        eng_d[i] <= eng_d[i-1];
        eng_c[i] <= eng_c[i-1];
      end
    end
  end

  assign crc_data_out = eng_d[LAT-1];
  assign crc_crc      = eng_c[LAT-1];

  // Reference CRC written bytewise, independent of the engine's bit loop.
  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [63:0] w);
    logic [31:0] r;
    logic [7:0]  b;
    r = c;
    for (int k = 0; k < 8; k++) begin
      b = w[8*k +: 8];
      r = r ^ {24'h0, b};
      for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  typedef struct {
    logic        sop;
    logic        eop;
    logic [63:0] data;
  } exp_t;

  exp_t        sb_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_fc  = '0;
  logic [15:0] exp_err = '0;
  bit          rand_or = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = rand_or ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: sample just before the rising edge; pop on each output transfer.
  initial begin
    exp_t        e;
    bit          prev_stall;
    logic [63:0] prev_data;
    logic [2:0]  prev_flags;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_flags = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_data", out_data, prev_data);
          check("hold_flags", {61'h0, out_valid, out_sop, out_eop}, {61'h0, prev_flags});
        end
        if (out_valid && out_ready) begin
          check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_sop_eop", {62'h0, out_sop, out_eop}, {62'h0, e.sop, e.eop});
          end
        end
        prev_stall = out_valid & ~out_ready;
        prev_data  = out_data;
        prev_flags = {out_valid, out_sop, out_eop};
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_word(input logic sop, input logic eop, input logic [63:0] d,
                           input logic exp_vin, input logic exp_init, output int waits);
    bit acc;
    acc      = 1'b0;
    waits    = 0;
    in_valid = 1'b1;
    in_sop   = sop;
    in_eop   = eop;
    in_data  = d;
    while (!acc && waits < 1000) begin
      #1;
      if (in_ready) begin
        acc = 1'b1;
        check("crc_valid_in", {63'h0, crc_valid_in}, {63'h0, exp_vin});
        check("crc_init_in", {63'h0, crc_init_in}, {63'h0, exp_init});
        check("crc_data_in", crc_data_in, d);
      end else begin
        waits++;
      end
      @(negedge clk);
    end
    if (!acc) check("accept_timeout", {63'h0, acc}, 64'd1);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit sop2, output int first_waits);
    logic [63:0] w;
    logic [31:0] c;
    int          waits;
    c           = 32'hFFFF_FFFF;
    first_waits = 0;
    for (int i = 0; i < len; i++) begin
      w = {$urandom, $urandom};
      c = crc_ref(c, w);
      sb_q.push_back('{sop: (i == 0), eop: 1'b0, data: w});
      send_word((i == 0) || (sop2 && i == 1), i == len - 1, w, 1'b1, i == 0, waits);
      if (i == 0) first_waits = waits;
      if (sop2 && i == 1) exp_err = sat_inc(exp_err);
    end
    sb_q.push_back('{sop: 1'b0, eop: 1'b1, data: {32'h0000_0000, ~c}});
    exp_fc = exp_fc + 32'd1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb_q.size() > 0 || out_valid) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(sb_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_data  = 64'hDEAD_BEEF_0BAD_F00D;
    repeat (3) @(negedge clk);
    #1;
    check("rst_crc_ce", {63'h0, crc_ce}, 64'd1);
    check("rst_crc_valid_in", {63'h0, crc_valid_in}, 64'd0);
    check("rst_in_ready", {63'h0, in_ready}, 64'd0);
    check("rst_out_valid", {63'h0, out_valid}, 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    exp_fc  = '0;
    exp_err = '0;
    @(negedge clk);
    check("rst_frame_count", 64'(frame_count), 64'(exp_fc));
    check("rst_err_count", 64'(err_count), 64'(exp_err));
    check("rst_in_ready_after", {63'h0, in_ready}, 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_data  = '0;
    rst_n    = 1'b0;
    @(negedge clk);
    apply_reset();

    // 3-word frame, continuous out_ready.
    send_frame(3, 1'b0, waits);
    check("t1_first_wait", 64'(waits), 64'd0);
    drain("t1_drain");
    check("t1_frame_count", 64'(frame_count), 64'(exp_fc));

    // Single-word frame immediately followed by another: one bubble cycle.
    send_frame(1, 1'b0, waits);
    send_frame(3, 1'b0, waits);
    check("t2_gap_bubble", 64'(waits), 64'd1);
    drain("t2_drain");
    check("t2_frame_count", 64'(frame_count), 64'(exp_fc));

    // 20 back-to-back frames with random backpressure.
    rand_or = 1'b1;
    for (int f = 0; f < 20; f++) send_frame(int'($urandom_range(1, 4)), 1'b0, waits);
    drain("t4_drain");
    rand_or = 1'b0;
    @(negedge clk);
    check("t4_frame_count", 64'(frame_count), 64'(exp_fc));
    check("t4_err_count", 64'(err_count), 64'(exp_err));

    // sop repeated on the second word: one error, CRC over all words.
    send_frame(3, 1'b1, waits);
    drain("t6_drain");
    check("t6_err_count", 64'(err_count), 64'(exp_err));
    check("t6_frame_count", 64'(frame_count), 64'(exp_fc));

    // Words without sop while idle are dropped; counter saturates.
    for (int i = 0; i < 65537; i++) begin
      send_word(1'b0, 1'b0, 64'(i), 1'b0, 1'b0, waits);
      exp_err = sat_inc(exp_err);
      if (i == 2) check("t3_err_partial", 64'(err_count), 64'(exp_err));
    end
    check("t3_err_sat", 64'(err_count), 64'h0000_0000_0000_FFFF);
    send_word(1'b0, 1'b1, 64'h1234, 1'b0, 1'b0, waits);
    check("t3_err_hold", 64'(err_count), 64'h0000_0000_0000_FFFF);
    check("t3_frame_count", 64'(frame_count), 64'(exp_fc));

    // Reset mid-frame; the aborted words are never expected at the output.
    send_word(1'b1, 1'b0, {$urandom, $urandom}, 1'b1, 1'b1, waits);
    send_word(1'b0, 1'b0, {$urandom, $urandom}, 1'b1, 1'b0, waits);
    apply_reset();
    send_frame(2, 1'b0, waits);
    drain("t5_drain");
    check("t5_frame_count", 64'(frame_count), 64'(exp_fc));
    check("t5_err_count", 64'(err_count), 64'(exp_err));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/crc32x64_frame_ctrl.md
Name: crc32x64_frame_ctrl

Overview:
- Sequences the 64-bit CRC32 pipeline engine (7-cycle latency, clock-enable stalled, no reset) for framed 64-bit word streams.
- Accepts sop/eop-delimited frames with a ready/valid handshake and drives the engine's ce/valid/init/data inputs.
- Tracks frame sideband through a matched delay line and appends one CRC trailer word after each frame's last word.
- Keeps frame and protocol-error counters; sits between the packetizer and the 10GbE transmit path.

Parameters:
- LATENCY, 7, engine input-to-output latency in ce cycles; sizes the sideband delay line.
- TRAILER_HI, 32'h0000_0000, value placed in bits [63:32] of the trailer word.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_sop  in  1  first word of frame
- in_eop  in  1  last word of frame; may coincide with in_sop
- in_data  in  64  input word
- in_ready  out  1  controller accepts the word this cycle
- out_ready  in  1  downstream accepts the output word
- out_valid  out  1  output word valid
- out_sop  out  1  first word of output frame
- out_eop  out  1  trailer word; always the last word of the frame
- out_data  out  64  frame data word or trailer
- crc_ce  out  1  engine clock enable
- crc_valid_in  out  1  engine valid_in
- crc_init_in  out  1  engine init_in
- crc_data_in  out  64  engine data_in
- crc_data_out  in  64  engine data_out
- crc_crc  in  32  engine crc; final CRC of the frame when aligned with the eop word
- frame_count  out  32  frames completed, i.e. trailers emitted; wraps
- err_count  out  16  protocol errors; saturates at 16'hFFFF

Behaviour:
- Reset:
  - All outputs, counters, state and delay line go to 0.
  - While rst_n=0: crc_ce=1 and crc_valid_in=0, which flushes the engine.
  - Stale engine output after reset is ignored because output qualification uses only the controller's own delay line.
- Stall:
  - ce = out_ready | ~out_valid.
  - crc_ce = ce when out of reset.
  - The delay line, the trailer logic and the output register advance only when ce=1.
- in_ready = ce & (state != GAP).
- An input word is accepted when in_valid & in_ready.
- Engine drive is combinational from the input:
  - crc_valid_in = accepted word that is not dropped.
  - crc_init_in = in_sop on the accepted word.
  - crc_data_in = in_data.
- State machine, advancing on ce cycles only:
  - IDLE, accepted word with sop: move to FRAME, or to GAP if eop is also set.
  - IDLE, accepted word without sop: word is dropped (crc_valid_in=0), err_count+1.
  - FRAME, accepted word with eop: move to GAP.
  - FRAME, accepted word with sop: treated as ordinary data (init not asserted), err_count+1.
  - GAP: in_ready=0 for exactly one ce cycle, then IDLE. This bubble is the output slot for the trailer.
- Delay line:
  - Entries {vld, sop, eop}, LATENCY deep, shift on ce.
  - Tail vld=1: out_valid=1, out_data=crc_data_out, out_sop=tail sop, out_eop=0.
  - Tail eop=1: capture crc_crc into crc_hold and set trailer_pend.
- Trailer:
  - On the next ce cycle (the bubble slot, tail vld=0) with trailer_pend=1: out_valid=1, out_data={TRAILER_HI, crc_hold}, out_eop=1.
  - Same cycle: clear trailer_pend, frame_count+1.
- Output latency: accepted word to out_valid = LATENCY ce cycles. Trailer follows the eop word on the next ce cycle.
- Outputs are registered.
- out_ready=0 holds every output stable.
- A single-word frame (sop & eop) yields 2 output words.

Test Plan:
- Reset, then a 3-word frame D0..D2 with out_ready=1 -> outputs D0 (out_sop=1), D1, D2, then trailer {0, CRC}. Trailer CRC equals reference CRC32 of the 24 bytes under the engine's init/final inversion. frame_count=1.
- Single-word frame (sop=eop=1) followed immediately by another frame -> in_ready low exactly 1 cycle after the eop. Output order: W0, trailer, then the next frame. Both CRCs match the model.
- Words with in_valid=1 and sop=0 while in IDLE -> no output, crc_valid_in=0, err_count increments per word. After 65536 such words err_count holds at 16'hFFFF.
- out_ready toggled randomly (50%) across 20 back-to-back frames -> no lost, duplicated or reordered words. All trailers correct. frame_count=20.
- rst_n pulsed low mid-frame, then a clean 2-word frame -> no output from the aborted frame. The new frame's trailer CRC is correct and counters restart from 0.
- Frame with sop asserted on its 2nd word -> err_count=1. The CRC covers all words from the first sop through the eop.
